// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state encoding
// and default cycle counts for a 25 MHz clock.
package btn_pkg;

  localparam int unsigned DEF_NUM_BTN         = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;     // 10 ms at 25 MHz
  localparam int unsigned DEF_LONG_CYCLES     = 25_000_000;  // 1 s at 25 MHz

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, edge pulses and an
// optional long-press detector (enabled by defining BTN_LONGPRESS_EN).
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that enters a PEND state is the first of the required run, so
  // the pending counter only needs to reach DEBOUNCE_CYCLES-2.
  localparam bit              FAST    = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] CNT_TGT =
    CNT_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

  logic             sync1;
  logic             sync2;
  logic             raw_pressed;
  btn_state_e       state;
  btn_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             press_next;
  logic             rel_next;

  assign raw_pressed = ~sync2;

  // Synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // FSM state and debounce counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_RELEASED: begin
        if (raw_pressed) begin
          state_next = FAST ? ST_PRESSED : ST_PRESS_PEND;
          cnt_next   = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!raw_pressed) begin
          state_next = ST_RELEASED;
          cnt_next   = '0;
        end else if (cnt == CNT_TGT) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!raw_pressed) begin
          state_next = FAST ? ST_RELEASED : ST_RELEASE_PEND;
          cnt_next   = '0;
        end
      end
      ST_RELEASE_PEND: begin
        if (raw_pressed) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_TGT) begin
          state_next = ST_RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // Pulses fire only on accepted transitions; glitch returns never pulse.
  always_comb begin
    level_next = (state_next == ST_PRESSED) || (state_next == ST_RELEASE_PEND);
    press_next = (state_next == ST_PRESSED) &&
                 ((state == ST_PRESS_PEND) || (state == ST_RELEASED));
    rel_next   = (state_next == ST_RELEASED) &&
                 ((state == ST_RELEASE_PEND) || (state == ST_PRESSED));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      level <= level_next;
      press <= press_next;
      rel   <= rel_next;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold;

  // Hold counter saturates at LONG_CYCLES so the pulse fires once per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= (state == ST_PRESSED) && (hold == HOLD_FIRE);
      if (state != ST_PRESSED) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounced, edge-detected button inputs: NUM_BTN independent channels.
// Optional long-press pulses when BTN_LONGPRESS_EN is defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_press,
  output logic [NUM_BTN-1:0] btn_long
);

  for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (btn_n[i]),
      .level      (btn_level[i]),
      .press      (btn_press[i]),
      .rel        (btn_release[i]),
      .long_pulse (btn_long[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (NUM_BTN=5, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Long-press expectations follow BTN_LONGPRESS_EN.
module tb_button_conditioner;

  localparam int unsigned NB = 5;

`ifdef BTN_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;
  logic [NB-1:0] btn_long;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [NB-1:0] btn_n;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [NB-1:0] lvl, input logic [NB-1:0] prs,
                         input logic [NB-1:0] rls, input logic [NB-1:0] lng);
    chk({tag, " level"},   32'(btn_level),   32'(lvl));
    chk({tag, " press"},   32'(btn_press),   32'(prs));
    chk({tag, " release"}, 32'(btn_release), 32'(rls));
    chk({tag, " any"},     32'(any_press),   32'(prs != '0));
    chk({tag, " long"},    32'(btn_long),    32'(lng));
  endtask

  task automatic add(input int n, input logic [NB-1:0] b, input logic [NB-1:0] l,
                     input logic [NB-1:0] p, input logic [NB-1:0] r);
    vec_t v;
    v.btn_n = b;
    v.level = l;
    v.press = p;
    v.rel   = r;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    // Row k: inputs driven after edge k, outputs expected after edge k+1.
    // Clean press/release on btn 0: pulses 6 cycles after each pin edge.
    add(5, 5'b11110, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b11110, 5'b00001, 5'b00001, 5'b00000);
    add(4, 5'b11110, 5'b00001, 5'b00000, 5'b00000);
    add(5, 5'b11111, 5'b00001, 5'b00000, 5'b00000);
    add(1, 5'b11111, 5'b00000, 5'b00000, 5'b00001);
    add(1, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    // 3-cycle glitch on btn 2 is rejected.
    add(3, 5'b11011, 5'b00000, 5'b00000, 5'b00000);
    add(9, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
    // Simultaneous press of btn 1 and 3, released 10 cycles later.
    add(5, 5'b10101, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b10101, 5'b01010, 5'b01010, 5'b00000);
    add(4, 5'b10101, 5'b01010, 5'b00000, 5'b00000);
    add(5, 5'b11111, 5'b01010, 5'b00000, 5'b00000);
    add(1, 5'b11111, 5'b00000, 5'b00000, 5'b01010);
    add(2, 5'b11111, 5'b00000, 5'b00000, 5'b00000);

    reset = 1'b1;
    btn_n = '1;
    step();
    step();
    step();
    chk_all("reset", '0, '0, '0, '0);
    reset = 1'b0;
    step();
    step();
    chk_all("idle", '0, '0, '0, '0);

    foreach (vecs[i]) begin
      btn_n = vecs[i].btn_n;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].level, vecs[i].press, vecs[i].rel, '0);
    end

    // Reset two cycles into btn 4 press-pending; button stays low throughout.
    btn_n = 5'b01111;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("pre_rst%0d", k), '0, '0, '0, '0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all($sformatf("in_rst%0d", k), '0, '0, '0, '0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("post_rst%0d", k), (k >= 6) ? 5'b10000 : 5'b00000,
              (k == 6) ? 5'b10000 : 5'b00000, '0, '0);
    end
    btn_n = '1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_all($sformatf("rel4_%0d", k), (k < 6) ? 5'b10000 : 5'b00000, '0,
              (k == 6) ? 5'b10000 : 5'b00000, '0);
    end

    // Btn 0 held 40 cycles: press at 6, long pulse 20 cycles later when enabled.
    btn_n = 5'b11110;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk_all($sformatf("hold%0d", k), (k >= 6) ? 5'b00001 : 5'b00000,
              (k == 6) ? 5'b00001 : 5'b00000, '0,
              (LONG_EN && k == 26) ? 5'b00001 : 5'b00000);
    end
    btn_n = '1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_all($sformatf("hold_rel%0d", k), (k < 6) ? 5'b00001 : 5'b00000, '0,
              (k == 6) ? 5'b00001 : 5'b00000, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5, number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); legal range 1..2^24-1.
REQ-003 SHALL have parameter LONG_CYCLES, default 25000000, hold time in cycles for a long-press event (used only with BTN_LONGPRESS_EN).
REQ-004 clk  input  1  system clock (the 25 MHz game clock); all logic on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_n  input  NUM_BTN  raw asynchronous button pins, active-low (0 = pressed).
REQ-007 btn_level  output  NUM_BTN  debounced pressed state, active-high.
REQ-008 btn_press  output  NUM_BTN  one-cycle pulse on accepted press.
REQ-009 btn_release  output  NUM_BTN  one-cycle pulse on accepted release.
REQ-010 any_press  output  1  OR of btn_press, same cycle.
REQ-011 btn_long  output  NUM_BTN  one-cycle long-press pulse; tied 0 when BTN_LONGPRESS_EN is undefined.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-flop synchronizer before any other use; raw_pressed = inverted synchronized bit.
REQ-013 Each channel SHALL run an independent FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-014 RELEASED -> PRESS_PEND when raw_pressed=1; PRESSED -> RELEASE_PEND when raw_pressed=0; counter cleared on entry.
REQ-015 In a PEND state the counter SHALL increment each cycle the raw value matches the pending value; a mismatch SHALL return to the prior stable state with counter cleared (glitch rejected, no pulse).
REQ-016 PRESS_PEND -> PRESSED when raw_pressed has been 1 for DEBOUNCE_CYCLES consecutive cycles; btn_press SHALL pulse for exactly the first cycle btn_level is 1.
REQ-017 RELEASE_PEND -> RELEASED symmetrically; btn_release pulses for the first cycle btn_level is 0.
REQ-018 Latency pin edge -> btn_press/btn_release SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-019 btn_level SHALL be 1 in PRESSED and RELEASE_PEND, 0 otherwise (no change until debounce completes).
REQ-020 Channels SHALL be fully independent; simultaneous accepted presses on several channels SHALL pulse simultaneously, and any_press SHALL be 1 for that one cycle.
REQ-021 Debounce counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)); counter SHALL never wrap.
REQ-022 btn_press and btn_release SHALL never be 1 on the same channel in the same cycle.

Reset
REQ-023 On reset: all FSMs RELEASED, counters 0, synchronizer flops 1 (released), all outputs 0 on the following cycle.
REQ-024 Reset mid-debounce SHALL discard the pending change without pulse; a button held through reset SHALL produce one btn_press 2 + DEBOUNCE_CYCLES cycles after reset deasserts.

Configuration
REQ-025 Macro BTN_LONGPRESS_EN defined: per-channel hold counter in PRESSED; btn_long SHALL pulse once when PRESSED has lasted LONG_CYCLES cycles, at most once per press, counter saturating; cleared on leaving PRESSED.
REQ-026 BTN_LONGPRESS_EN undefined: hold counters absent from netlist, btn_long constant 0, all other behaviour identical.

Structure
REQ-027 Shared package btn_pkg SHALL hold the FSM state enum and default constants (debounce/long-press cycle counts at 25 MHz).
REQ-028 One sub-module btn_debounce_ch (synchronizer + FSM + counters for one channel) SHALL be instantiated NUM_BTN times; top level adds only any_press reduction.

Verification (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, NUM_BTN=5)
REQ-029 btn_n[0] 1->0 held -> btn_press[0] pulses exactly 6 cycles after edge, btn_level[0]=1 from that cycle.
REQ-030 btn_n[2] low for 3 cycles then high -> no btn_press, btn_level[2] stays 0.
REQ-031 btn_n[1] and btn_n[3] fall same cycle -> btn_press=5'b01010 in one cycle, any_press=1 once; release 10 cycles later -> btn_release=5'b01010 6 cycles after rising edge.
REQ-032 reset asserted 2 cycles into PRESS_PEND of btn 4, button kept low -> no pulse during reset; btn_press[4] exactly 6 cycles after reset deasserts.
REQ-033 With BTN_LONGPRESS_EN: btn_n[0] held 40 cycles -> one btn_long[0] pulse 20 cycles after btn_press[0], none further; without macro btn_long stays 0.
